// File: rtl/aukv_decode_if.sv
// Auk-V decode stage bus: fetch-side inputs, downstream stall/flush and the
// registered decode outputs. Clock and reset stay as plain module ports.
interface aukv_decode_if;
  logic [31:0] i_pc;
  logic [31:0] i_instr;
  logic        i_instr_valid;
  logic        i_stall;
  logic        i_flush;
  logic        o_stall;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [31:0] o_instr;
  logic [3:0]  o_opclass;
  logic [2:0]  o_funct3;
  logic        o_alu_alt;
  logic [4:0]  o_rs1;
  logic [4:0]  o_rs2;
  logic [4:0]  o_rd;
  logic        o_rd_we;
  logic [31:0] o_imm;
  logic        o_illegal;

  // Fetch/execute side: drives instructions and control, observes decode.
  modport master (
    output i_pc, i_instr, i_instr_valid, i_stall, i_flush,
    input  o_stall, o_valid, o_pc, o_instr, o_opclass, o_funct3, o_alu_alt,
           o_rs1, o_rs2, o_rd, o_rd_we, o_imm, o_illegal
  );

  // Decode stage side.
  modport slave (
    input  i_pc, i_instr, i_instr_valid, i_stall, i_flush,
    output o_stall, o_valid, o_pc, o_instr, o_opclass, o_funct3, o_alu_alt,
           o_rs1, o_rs2, o_rd, o_rd_we, o_imm, o_illegal
  );
endinterface

// File: rtl/aukv_decode.sv
// Auk-V RV32I decode stage: combinational decode of the fetched instruction
// into a single registered output bank, with load-use bubble insertion,
// flush squashing and downstream-stall hold.
module aukv_decode (
  input  logic         i_clk,
  input  logic         i_rst,
  aukv_decode_if.slave bus
);

  typedef enum logic [3:0] {
    OPC_NONE   = 4'd0,
    OPC_LUI    = 4'd1,
    OPC_AUIPC  = 4'd2,
    OPC_JAL    = 4'd3,
    OPC_JALR   = 4'd4,
    OPC_BRANCH = 4'd5,
    OPC_LOAD   = 4'd6,
    OPC_STORE  = 4'd7,
    OPC_OPIMM  = 4'd8,
    OPC_OP     = 4'd9,
    OPC_FENCE  = 4'd10,
    OPC_SYSTEM = 4'd11
  } opclass_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [3:0]  opclass;
    logic [2:0]  funct3;
    logic        alu_alt;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] imm;
    logic        illegal;
  } dec_t;

  // Bubble: a canonical NOP (add x0,x0,x0) that is not valid.
  function automatic dec_t bubble_f(input logic [31:0] pc);
    dec_t b;
    b       = '0;
    b.pc    = pc;
    b.instr = 32'h0000_0033;
    return b;
  endfunction

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  logic [31:0] imm_i_s, imm_st_s, imm_b_s, imm_u_s, imm_j_s;
  opclass_e    opclass_s;
  logic        legal_s, use_rs1_s, use_rs2_s, use_rd_s;
  logic [31:0] imm_s;
  logic [4:0]  rs1_s, rs2_s, rd_s;
  logic        hazard_s;
  dec_t        dec_s, next_s, out_r;

  assign opcode_s = bus.i_instr[6:0];
  assign funct3_s = bus.i_instr[14:12];
  assign funct7_s = bus.i_instr[31:25];

  assign imm_i_s  = {{20{bus.i_instr[31]}}, bus.i_instr[31:20]};
  assign imm_st_s = {{20{bus.i_instr[31]}}, bus.i_instr[31:25], bus.i_instr[11:7]};
  assign imm_b_s  = {{19{bus.i_instr[31]}}, bus.i_instr[31], bus.i_instr[7],
                     bus.i_instr[30:25], bus.i_instr[11:8], 1'b0};
  assign imm_u_s  = {bus.i_instr[31:12], 12'd0};
  assign imm_j_s  = {{11{bus.i_instr[31]}}, bus.i_instr[31], bus.i_instr[19:12],
                     bus.i_instr[20], bus.i_instr[30:21], 1'b0};

  // Classify the opcode, check legality and pick used fields and immediate.
  always_comb begin
    opclass_s = OPC_NONE;
    legal_s   = 1'b0;
    use_rs1_s = 1'b0;
    use_rs2_s = 1'b0;
    use_rd_s  = 1'b0;
    imm_s     = 32'd0;
    case (opcode_s)
      7'b0110111: begin
        opclass_s = OPC_LUI;   legal_s = 1'b1; use_rd_s = 1'b1; imm_s = imm_u_s;
      end
      7'b0010111: begin
        opclass_s = OPC_AUIPC; legal_s = 1'b1; use_rd_s = 1'b1; imm_s = imm_u_s;
      end
      7'b1101111: begin
        opclass_s = OPC_JAL;   legal_s = 1'b1; use_rd_s = 1'b1; imm_s = imm_j_s;
      end
      7'b1100111: begin
        opclass_s = OPC_JALR;  legal_s = (funct3_s == 3'b000);
        use_rd_s  = 1'b1; use_rs1_s = 1'b1; imm_s = imm_i_s;
      end
      7'b1100011: begin
        opclass_s = OPC_BRANCH;
        legal_s   = (funct3_s != 3'b010) && (funct3_s != 3'b011);
        use_rs1_s = 1'b1; use_rs2_s = 1'b1; imm_s = imm_b_s;
      end
      7'b0000011: begin
        opclass_s = OPC_LOAD;
        legal_s   = (funct3_s == 3'b000) || (funct3_s == 3'b001) || (funct3_s == 3'b010) ||
                    (funct3_s == 3'b100) || (funct3_s == 3'b101);
        use_rd_s  = 1'b1; use_rs1_s = 1'b1; imm_s = imm_i_s;
      end
      7'b0100011: begin
        opclass_s = OPC_STORE; legal_s = (funct3_s <= 3'b010);
        use_rs1_s = 1'b1; use_rs2_s = 1'b1; imm_s = imm_st_s;
      end
      7'b0010011: begin
        opclass_s = OPC_OPIMM;
        if (funct3_s == 3'b001) begin
          legal_s = (funct7_s == 7'b0000000);
        end else if (funct3_s == 3'b101) begin
          legal_s = (funct7_s == 7'b0000000) || (funct7_s == 7'b0100000);
        end else begin
          legal_s = 1'b1;
        end
        use_rd_s = 1'b1; use_rs1_s = 1'b1; imm_s = imm_i_s;
      end
      7'b0110011: begin
        opclass_s = OPC_OP;
        legal_s   = (funct7_s == 7'b0000000) ||
                    ((funct7_s == 7'b0100000) && ((funct3_s == 3'b000) || (funct3_s == 3'b101)));
        use_rd_s  = 1'b1; use_rs1_s = 1'b1; use_rs2_s = 1'b1;
      end
      7'b0001111: begin
        opclass_s = OPC_FENCE; legal_s = 1'b1;
      end
      7'b1110011: begin
        // CSR forms read rs1 and write rd; the CSR address is not an operand immediate.
        opclass_s = OPC_SYSTEM; legal_s = 1'b1; use_rd_s = 1'b1; use_rs1_s = 1'b1;
      end
      default: begin
        legal_s = 1'b0;
      end
    endcase
  end

  // Unused or illegal fields read as x0 so they never create a false hazard.
  assign rs1_s = (legal_s && use_rs1_s) ? bus.i_instr[19:15] : 5'd0;
  assign rs2_s = (legal_s && use_rs2_s) ? bus.i_instr[24:20] : 5'd0;
  assign rd_s  = (legal_s && use_rd_s)  ? bus.i_instr[11:7]  : 5'd0;

  // Assemble the decoded record for a valid incoming instruction.
  always_comb begin
    dec_s = bubble_f(bus.i_pc);
    if (legal_s) begin
      dec_s.valid   = 1'b1;
      dec_s.instr   = bus.i_instr;
      dec_s.opclass = opclass_s;
      dec_s.funct3  = funct3_s;
      dec_s.alu_alt = ((opclass_s == OPC_OP) ||
                       ((opclass_s == OPC_OPIMM) && (funct3_s == 3'b101))) ? bus.i_instr[30] : 1'b0;
      dec_s.rs1     = rs1_s;
      dec_s.rs2     = rs2_s;
      dec_s.rd      = rd_s;
      dec_s.rd_we   = (rd_s != 5'd0);
      dec_s.imm     = imm_s;
      dec_s.illegal = 1'b0;
    end else begin
      dec_s.valid   = 1'b1;
      dec_s.instr   = bus.i_instr;
      dec_s.funct3  = funct3_s;
      dec_s.illegal = 1'b1;
    end
  end

  // Load-use: the load in the output register feeds a source of the incoming instruction.
  assign hazard_s = out_r.valid && (out_r.opclass == OPC_LOAD) && out_r.rd_we &&
                    bus.i_instr_valid && !bus.i_flush &&
                    ((rs1_s == out_r.rd) || (rs2_s == out_r.rd));

  assign bus.o_stall = bus.i_stall | hazard_s;

  // Register update priority: flush, downstream hold, hazard bubble, then load.
  always_comb begin
    next_s = out_r;
    if (bus.i_flush) begin
      next_s = bubble_f(32'd0);
    end else if (bus.i_stall) begin
      next_s = out_r;
    end else if (hazard_s) begin
      next_s = bubble_f(32'd0);
    end else if (bus.i_instr_valid) begin
      next_s = dec_s;
    end else begin
      next_s = bubble_f(bus.i_pc);
    end
  end

  // Output register bank; reset loads the bubble immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_r <= bubble_f(32'd0);
    end else begin
      out_r <= next_s;
    end
  end

  assign bus.o_valid   = out_r.valid;
  assign bus.o_pc      = out_r.pc;
  assign bus.o_instr   = out_r.instr;
  assign bus.o_opclass = out_r.opclass;
  assign bus.o_funct3  = out_r.funct3;
  assign bus.o_alu_alt = out_r.alu_alt;
  assign bus.o_rs1     = out_r.rs1;
  assign bus.o_rs2     = out_r.rs2;
  assign bus.o_rd      = out_r.rd;
  assign bus.o_rd_we   = out_r.rd_we;
  assign bus.o_imm     = out_r.imm;
  assign bus.o_illegal = out_r.illegal;

endmodule

// File: tb/tb_aukv_decode.sv
// Self-checking bench for aukv_decode: directed scenarios followed by random
// instruction streams compared against an instruction-level reference model.
module tb_aukv_decode;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [3:0]  opc;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] imm;
    logic        ill;
  } rec_t;

  logic clk;
  logic rst;
  aukv_decode_if bus ();

  aukv_decode dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int   chk_cnt;
  int   pass_cnt;
  rec_t exp_q;
  logic exp_stall;
  logic obs_stall;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic rec_t bubble(input logic [31:0] pc);
    rec_t r;
    r       = '0;
    r.pc    = pc;
    r.instr = 32'h0000_0033;
    return r;
  endfunction

  // Instruction-level reference: class/format table, legality sets, arithmetic immediates.
  function automatic rec_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    rec_t       r;
    logic [2:0] f3;
    logic [6:0] f7;
    int         cls;
    bit         ok;
    string      fmt;
    f3 = ins[14:12];
    f7 = ins[31:25];
    cls = 0; ok = 1'b0; fmt = "-";
    case (ins[6:0])
      7'b0110111: begin cls = 1;  fmt = "U"; ok = 1'b1; end
      7'b0010111: begin cls = 2;  fmt = "U"; ok = 1'b1; end
      7'b1101111: begin cls = 3;  fmt = "J"; ok = 1'b1; end
      7'b1100111: begin cls = 4;  fmt = "I"; ok = (f3 == 3'd0); end
      7'b1100011: begin cls = 5;  fmt = "B"; ok = !(f3 inside {3'd2, 3'd3}); end
      7'b0000011: begin cls = 6;  fmt = "I"; ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}); end
      7'b0100011: begin cls = 7;  fmt = "S"; ok = (f3 inside {3'd0, 3'd1, 3'd2}); end
      7'b0010011: begin
        cls = 8; fmt = "I";
        if (f3 == 3'd1)      ok = (f7 == 7'd0);
        else if (f3 == 3'd5) ok = (f7 inside {7'd0, 7'h20});
        else                 ok = 1'b1;
      end
      7'b0110011: begin cls = 9;  fmt = "R"; ok = (f7 == 7'd0) || (f7 == 7'h20 && (f3 inside {3'd0, 3'd5})); end
      7'b0001111: begin cls = 10; fmt = "N"; ok = 1'b1; end
      7'b1110011: begin cls = 11; fmt = "C"; ok = 1'b1; end
      default:    begin cls = 0;  ok = 1'b0; end
    endcase
    r       = '0;
    r.valid = 1'b1;
    r.pc    = pc;
    r.instr = ins;
    r.f3    = f3;
    if (!ok) begin
      r.ill = 1'b1;
      return r;
    end
    r.opc = 4'(cls);
    if (fmt == "U" || fmt == "J" || fmt == "I" || fmt == "R" || fmt == "C") r.rd  = ins[11:7];
    if (fmt == "I" || fmt == "S" || fmt == "B" || fmt == "R" || fmt == "C") r.rs1 = ins[19:15];
    if (fmt == "S" || fmt == "B" || fmt == "R")                             r.rs2 = ins[24:20];
    if (fmt == "I") r.imm = 32'(int'($signed(ins[31:20])));
    if (fmt == "S") r.imm = 32'(int'($signed({ins[31:25], ins[11:7]})));
    if (fmt == "B") r.imm = 32'(-4096 * int'(ins[31]) + 2048 * int'(ins[7]) +
                                32 * int'(ins[30:25]) + 2 * int'(ins[11:8]));
    if (fmt == "U") r.imm = ins & 32'hFFFF_F000;
    if (fmt == "J") r.imm = 32'(-1048576 * int'(ins[31]) + 4096 * int'(ins[19:12]) +
                                2048 * int'(ins[20]) + 2 * int'(ins[30:21]));
    r.we  = (r.rd != 5'd0);
    r.alt = (cls == 9 || (cls == 8 && f3 == 3'd5)) ? ins[30] : 1'b0;
    return r;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".valid"},   32'(bus.o_valid),   32'(exp_q.valid));
    check({tag, ".pc"},      bus.o_pc,           exp_q.pc);
    check({tag, ".instr"},   bus.o_instr,        exp_q.instr);
    check({tag, ".opclass"}, 32'(bus.o_opclass), 32'(exp_q.opc));
    check({tag, ".funct3"},  32'(bus.o_funct3),  32'(exp_q.f3));
    check({tag, ".alu_alt"}, 32'(bus.o_alu_alt), 32'(exp_q.alt));
    check({tag, ".rs1"},     32'(bus.o_rs1),     32'(exp_q.rs1));
    check({tag, ".rs2"},     32'(bus.o_rs2),     32'(exp_q.rs2));
    check({tag, ".rd"},      32'(bus.o_rd),      32'(exp_q.rd));
    check({tag, ".rd_we"},   32'(bus.o_rd_we),   32'(exp_q.we));
    check({tag, ".imm"},     bus.o_imm,          exp_q.imm);
    check({tag, ".illegal"}, 32'(bus.o_illegal), 32'(exp_q.ill));
  endtask

  // One clock: check the combinational stall mid-cycle, then the registered outputs after the edge.
  task automatic step(input string tag);
    rec_t d;
    rec_t nxt;
    logic haz;
    @(negedge clk);
    d   = ref_decode(bus.i_instr, bus.i_pc);
    haz = exp_q.valid && exp_q.opc == 4'd6 && exp_q.we && bus.i_instr_valid && !bus.i_flush &&
          (d.rs1 == exp_q.rd || d.rs2 == exp_q.rd);
    exp_stall = bus.i_stall | haz;
    obs_stall = bus.o_stall;
    check({tag, ".stall"}, 32'(obs_stall), 32'(exp_stall));
    if (bus.i_flush)             nxt = bubble(32'd0);
    else if (bus.i_stall)        nxt = exp_q;
    else if (haz)                nxt = bubble(32'd0);
    else if (bus.i_instr_valid)  nxt = d;
    else                         nxt = bubble(bus.i_pc);
    @(posedge clk);
    #1;
    exp_q = nxt;
    compare_all(tag);
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] ins, input logic v,
                       input logic st, input logic fl);
    bus.i_pc          = pc;
    bus.i_instr       = ins;
    bus.i_instr_valid = v;
    bus.i_stall       = st;
    bus.i_flush       = fl;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 12);
    case (k)
      0:  r[6:0] = 7'b0110111;
      1:  r[6:0] = 7'b0010111;
      2:  r[6:0] = 7'b1101111;
      3:  r[6:0] = 7'b1100111;
      4:  r[6:0] = 7'b1100011;
      5:  r[6:0] = 7'b0000011;
      6:  r[6:0] = 7'b0000011;
      7:  r[6:0] = 7'b0100011;
      8:  r[6:0] = 7'b0010011;
      9:  r[6:0] = 7'b0110011;
      10: r[6:0] = 7'b0001111;
      11: r[6:0] = 7'b1110011;
      default: r[6:0] = r[6:0];
    endcase
    if ($urandom_range(0, 3) != 0) begin
      r[11:7]  = 5'($urandom_range(0, 3));
      r[19:15] = 5'($urandom_range(0, 3));
      r[24:20] = 5'($urandom_range(0, 3));
    end
    if (k == 8 || k == 9) begin
      case ($urandom_range(0, 2))
        0:       r[31:25] = 7'h00;
        1:       r[31:25] = 7'h20;
        default: r[31:25] = r[31:25];
      endcase
    end
    return r;
  endfunction

  initial begin
    logic [31:0] pc;
    logic [31:0] ins;
    logic        v;
    chk_cnt = 0;
    pass_cnt = 0;
    drive(32'd0, 32'h0000_0033, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    exp_q = bubble(32'd0);
    exp_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    rst = 1'b0;

    // addi x1,x0,5
    drive(32'h8000_0000, 32'h0050_0093, 1'b1, 1'b0, 1'b0);
    step("addi");
    check("addi.opclass_c", 32'(bus.o_opclass), 32'd8);
    check("addi.rd_c",      32'(bus.o_rd),      32'd1);
    check("addi.imm_c",     bus.o_imm,          32'd5);
    check("addi.rd_we_c",   32'(bus.o_rd_we),   32'd1);
    check("addi.pc_c",      bus.o_pc,           32'h8000_0000);

    // lw x2,0(x1) then add x3,x2,x2 held by fetch while stalled
    drive(32'h8000_0004, 32'h0000_A103, 1'b1, 1'b0, 1'b0);
    step("lw");
    check("lw.opclass_c", 32'(bus.o_opclass), 32'd6);
    drive(32'h8000_0008, 32'h0021_01B3, 1'b1, 1'b0, 1'b0);
    step("lu_bubble");
    check("lu.stall_first_c", 32'(obs_stall), 32'd1);
    check("lu.bubble_valid_c", 32'(bus.o_valid), 32'd0);
    step("lu_add");
    check("lu.stall_second_c", 32'(obs_stall), 32'd0);
    check("lu.add_opclass_c", 32'(bus.o_opclass), 32'd9);
    check("lu.add_rs1_c", 32'(bus.o_rs1), 32'd2);
    check("lu.add_rs2_c", 32'(bus.o_rs2), 32'd2);
    check("lu.add_rd_c",  32'(bus.o_rd),  32'd3);

    // beq x0,x0,-8
    drive(32'h8000_000C, 32'hFE00_0CE3, 1'b1, 1'b0, 1'b0);
    step("beq");
    check("beq.opclass_c", 32'(bus.o_opclass), 32'd5);
    check("beq.imm_c",     bus.o_imm,          32'hFFFF_FFF8);
    check("beq.rd_we_c",   32'(bus.o_rd_we),   32'd0);

    // downstream stall for three cycles holds the branch
    drive(32'h8000_0010, 32'h0050_0093, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("hold");
      check("hold.opclass_c", 32'(bus.o_opclass), 32'd5);
      check("hold.pc_c",      bus.o_pc,           32'h8000_000C);
    end
    // flush while stalled loads a bubble
    drive(32'h8000_0010, 32'h0050_0093, 1'b1, 1'b1, 1'b1);
    step("flush_stall");
    check("flush.valid_c", 32'(bus.o_valid), 32'd0);
    check("flush.instr_c", bus.o_instr,      32'h0000_0033);

    // illegal encodings
    drive(32'h8000_0014, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    step("ill_ones");
    check("ill1.valid_c",   32'(bus.o_valid),   32'd1);
    check("ill1.illegal_c", 32'(bus.o_illegal), 32'd1);
    check("ill1.rd_we_c",   32'(bus.o_rd_we),   32'd0);
    drive(32'h8000_0018, 32'h4020_91B3, 1'b1, 1'b0, 1'b0);
    step("ill_op");
    check("ill2.illegal_c", 32'(bus.o_illegal), 32'd1);

    // flush coinciding with a load-use hazard: flush wins, no stall
    drive(32'h8000_001C, 32'h0000_2283, 1'b1, 1'b0, 1'b0);
    step("lw_x5");
    drive(32'h8000_0020, 32'h0002_8333, 1'b1, 1'b0, 1'b1);
    step("haz_flush");
    check("haz_flush.stall_c", 32'(obs_stall), 32'd0);

    // stall coinciding with a hazard: hold, then bubble, then the consumer
    drive(32'h8000_0024, 32'h0000_2283, 1'b1, 1'b0, 1'b0);
    step("lw_x5b");
    drive(32'h8000_0028, 32'h0002_8333, 1'b1, 1'b1, 1'b0);
    step("haz_stall1");
    check("haz_stall.held_c", 32'(bus.o_opclass), 32'd6);
    drive(32'h8000_0028, 32'h0002_8333, 1'b1, 1'b0, 1'b0);
    step("haz_bubble");
    step("haz_consumer");
    check("haz_stall.consumer_c", 32'(bus.o_rd), 32'd6);

    // asynchronous reset mid-cycle
    drive(32'h8000_002C, 32'h0050_0093, 1'b1, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid.valid", 32'(bus.o_valid), 32'd0);
    check("rst_mid.instr", bus.o_instr,      32'h0000_0033);
    check("rst_mid.stall", 32'(bus.o_stall), 32'd1);
    exp_q = bubble(32'd0);
    exp_stall = 1'b0;
    @(posedge clk);
    #1;
    compare_all("rst_held");
    rst = 1'b0;

    // random streams; fetch holds its instruction while the model says stall
    pc = 32'h0000_1000;
    ins = 32'h0000_0033;
    v = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!exp_stall) begin
        pc  = pc + 32'd4;
        ins = rand_instr();
        v   = ($urandom_range(0, 9) != 0);
      end
      drive(pc, ins, v, ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0));
      step("rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/aukv_decode.md
# aukv_decode

Decode stage of the Auk-V RV32I 5-stage pipeline. It sits between fetch and execute and decodes one instruction per cycle into registered control, register-index and immediate fields. It detects load-use hazards, requests a one-cycle fetch stall and inserts a bubble. It also squashes its output on branch or exception flush and holds its output while the downstream stage stalls.

## Interface
- No parameters.
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_pc  in  32  PC of the incoming instruction, from fetch.
- i_instr  in  32  incoming instruction; fetch drives 32'h33 when it has no instruction.
- i_instr_valid  in  1  the incoming instruction is valid.
- i_stall  in  1  downstream stall; hold all output registers.
- i_flush  in  1  branch taken or exception; squash the output register.
- o_stall  out  1  stall request to fetch, combinational: i_stall | hazard.
- o_valid  out  1  the registered instruction is valid.
- o_pc  out  32  registered PC.
- o_instr  out  32  registered raw instruction.
- o_opclass  out  4  instruction class:
  - 0 NONE, 1 LUI, 2 AUIPC, 3 JAL, 4 JALR, 5 BRANCH,
  - 6 LOAD, 7 STORE, 8 OPIMM, 9 OP, 10 FENCE, 11 SYSTEM.
- o_funct3  out  3  instr[14:12].
- o_alu_alt  out  1  instr[30] for OP, and for OPIMM shifts with funct3=101; 0 otherwise.
- o_rs1, o_rs2, o_rd  out  5 each  register indices. An index is forced to 0 when the format does not use that field.
- o_rd_we  out  1  the instruction writes rd, and rd != 0.
- o_imm  out  32  sign-extended immediate (I/S/B/U/J format). 0 for OP, FENCE and SYSTEM.
- o_illegal  out  1  the registered valid instruction is illegal.

## Operation
- The decoder is combinational on i_instr. It feeds a single output register bank.
- Register update, in priority order:
  1. i_rst: load the bubble immediately.
  2. i_flush: load the bubble.
  3. i_stall: hold all outputs.
  4. hazard: load the bubble.
  5. Otherwise: load the decoded i_instr, with o_valid = i_instr_valid.
- Bubble: o_valid=0, o_instr=32'h33, o_opclass=0, o_illegal=0, o_rd_we=0. All other outputs are 0, including o_pc.
- An invalid input also loads bubble fields; only o_pc tracks i_pc.
- Hazard, combinational: asserted when all of the following hold:
  - o_valid & (o_opclass==LOAD) & o_rd_we;
  - i_instr_valid & ~i_flush;
  - the decoded rs1 or rs2 of the incoming instruction equals o_rd.
- The comparison uses the forced-to-0 indices, so fields a format does not use never match.
- Fetch holds its instruction while o_stall=1. In the next cycle the register holds a bubble, so the hazard clears. Each load-use pair therefore costs exactly one bubble.
- Legality:
  - Valid opcodes: 0110111, 0010111, 1101111, 1100111 (funct3=000), 1100011 (funct3 not 010/011), 0000011 (funct3 in 000,001,010,100,101), 0100011 (funct3 in 000..010), 0010011, 0110011, 0001111, 1110011.
  - OP: funct7 must be 0000000, or 0100000 with funct3 000 or 101.
  - OPIMM shifts: funct3=001 requires funct7=0; funct3=101 requires funct7 = 0 or 0100000.
  - instr[1:0] != 11 is illegal.
- An illegal instruction loads with o_valid=1, o_illegal=1, o_opclass=0, o_rd_we=0, and o_rs1/o_rs2/o_rd/o_imm=0.
- Immediate formats:
  - I = {{20{i[31]}}, i[31:20]}
  - S = {{20{i[31]}}, i[31:25], i[11:7]}
  - B = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 0}
  - U = {i[31:12], 12'b0}
  - J = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 0}

## Timing
- Latency: 1 cycle from i_instr to the o_* registers.
- o_stall is combinational and is driven in the same cycle as the hazard or i_stall.
- When i_flush and hazard coincide, the flush wins: o_stall = i_stall only.
- When i_stall and i_flush coincide, the register loads the bubble. Flush overrides hold.
- When i_stall and hazard coincide, the register holds; the hazard bubble is inserted once i_stall deasserts.
- Reset mid-operation: the bubble is asynchronous and immediate; o_stall follows i_stall.
- With continuous valid input and no stalls, one instruction is issued per cycle, with no gaps.

## Test plan
- Reset: assert i_rst mid-stream. Required: o_valid=0, o_instr=32'h33, o_stall=i_stall.
- ALU decode: feed addi x1,x0,5 (32'h00500093) at pc 32'h80000000. Required one cycle later:
  - o_opclass=8, o_rd=1, o_rs1=0, o_rs2=0, o_imm=5;
  - o_rd_we=1, o_pc=32'h80000000.
- Load-use: feed lw x2,0(x1) (32'h0000A103), then add x3,x2,x2 (32'h002101B3), which fetch holds while stalled. Required:
  - o_stall=1 for exactly one cycle;
  - the output sequence is LOAD, bubble, then OP with o_rs1=o_rs2=2 and o_rd=3.
- Branch immediate: feed beq x0,x0,-8 (32'hFE000CE3). Required: o_opclass=5, o_imm=32'hFFFFFFF8, o_rd_we=0.
- Flush and stall:
  - Hold i_stall for 3 cycles. Required: outputs unchanged.
  - Pulse i_flush with i_stall high. Required: a bubble on the next edge.
- Illegal: feed 32'hFFFFFFFF. Required: o_valid=1, o_illegal=1, o_rd_we=0.
- Illegal: feed OP with funct7=0100000 and funct3=001. Required: o_illegal=1.
